// File: rtl/led_ring_pkg.sv
// -----------------------------------------------------------------------------
// led_ring_pkg
//   Shared types and defaults for the LED ring checkers.
//
//   ring_state_t   : lock state of the ring decoder (SEARCH, ACQUIRE, LOCKED).
//   sample_class_t : shape of one observed ring pattern (ZERO, ONEHOT, MULTI).
//   LED_W_DEFAULT  : default ring width used by the generator/decoder pair.
//   MISS_W         : width of the consecutive-miss counter (covers 1..15).
// -----------------------------------------------------------------------------
package led_ring_pkg;

  localparam int LED_W_DEFAULT = 16;
  localparam int MISS_W        = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } ring_state_t;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    ONEHOT = 2'd1,
    MULTI  = 2'd2
  } sample_class_t;

endpackage : led_ring_pkg

// File: rtl/onehot_classify.sv
// -----------------------------------------------------------------------------
// onehot_classify
//   Purely combinational classifier for a ring pattern. Reports whether the
//   pattern is all-zero, exactly one-hot, or has several bits set, and the
//   index of the set bit. idx is only meaningful when sample_class == ONEHOT.
//
//   Ports
//     pattern_in   [LED_W-1:0]  observed ring pattern
//     sample_class              ZERO / ONEHOT / MULTI
//     idx          [POS_W-1:0]  index of the lit bit (valid for ONEHOT)
// -----------------------------------------------------------------------------
module onehot_classify
  import led_ring_pkg::*;
#(
  parameter int LED_W = LED_W_DEFAULT,
  parameter int POS_W = $clog2(LED_W)
) (
  input  logic [LED_W-1:0] pattern_in,
  output sample_class_t    sample_class,
  output logic [POS_W-1:0] idx
);

  // Clearing the lowest set bit leaves zero only when a single bit was set.
  logic [LED_W-1:0] low_bit_cleared;
  assign low_bit_cleared = pattern_in & (pattern_in - LED_W'(1));

  always_comb begin
    if (pattern_in == '0) begin
      sample_class = ZERO;
    end else if (low_bit_cleared == '0) begin
      sample_class = ONEHOT;
    end else begin
      sample_class = MULTI;
    end
  end

  // Priority scan: the highest set bit wins, which for a one-hot input is
  // simply the only set bit.
  always_comb begin
    idx = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (pattern_in[i]) begin
        idx = POS_W'(i);
      end
    end
  end

endmodule : onehot_classify

// File: rtl/led_ring_decoder.sv
// -----------------------------------------------------------------------------
// led_ring_decoder
//   Receive-side checker for the rotating LED ring. Each qualified sample is
//   classified; a one-hot sample gives the lit position. The decoder searches
//   for a lit bit, acquires a rotation direction from the first adjacent step,
//   then stays locked while the ring keeps stepping the same way, counting
//   steps and pulsing err on every bad sample. MISS_LIMIT consecutive bad
//   samples drop the lock.
//
//   Ports
//     clk_out     divided clock, all state updates on its rising edge
//     rst         asynchronous, active-high reset
//     sample_en   qualifies pattern_in for one cycle
//     pattern_in  [LED_W-1:0] observed ring pattern
//     pos         [POS_W-1:0] lit index of the last good sample
//     dir         1 = index decrementing, 0 = index incrementing
//     locked      high while in LOCKED
//     err         one-cycle pulse for each bad sample while locked
//     step_count  [CNT_W-1:0] good steps since lock, saturating
// -----------------------------------------------------------------------------
module led_ring_decoder
  import led_ring_pkg::*;
#(
  parameter int LED_W      = LED_W_DEFAULT,
  parameter int POS_W      = $clog2(LED_W),
  parameter int MISS_LIMIT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [LED_W-1:0] pattern_in,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] step_count
);

  // ---------------------------------------------------------------------------
  // Sample classification
  // ---------------------------------------------------------------------------
  sample_class_t    sample_class;
  logic [POS_W-1:0] idx;

  onehot_classify #(
    .LED_W (LED_W),
    .POS_W (POS_W)
  ) u_classify (
    .pattern_in   (pattern_in),
    .sample_class (sample_class),
    .idx          (idx)
  );

  // ---------------------------------------------------------------------------
  // State
  //   The previous position always moves together with pos, so the pos
  //   register doubles as prev_pos.
  // ---------------------------------------------------------------------------
  ring_state_t       state_q, state_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [POS_W-1:0]  pos_d;
  logic              dir_d;
  logic              locked_d;
  logic              err_d;
  logic [CNT_W-1:0]  step_count_d;

  // Step relations; POS_W-bit arithmetic wraps modulo LED_W because LED_W is
  // a power of two.
  logic is_onehot;
  logic is_hold;
  logic is_dec;
  logic is_inc;
  logic fwd_step;

  assign is_onehot = (sample_class == ONEHOT);
  assign is_hold   = is_onehot && (idx == pos);
  assign is_dec    = is_onehot && (idx == pos - POS_W'(1));
  assign is_inc    = is_onehot && (idx == pos + POS_W'(1));
  assign fwd_step  = dir ? is_dec : is_inc;

  logic [MISS_W-1:0] miss_cnt_inc;
  assign miss_cnt_inc = miss_cnt_q + MISS_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    miss_cnt_d   = miss_cnt_q;
    pos_d        = pos;
    dir_d        = dir;
    err_d        = 1'b0;
    step_count_d = step_count;

    if (sample_en) begin
      unique case (state_q)
        SEARCH: begin
          if (is_onehot) begin
            pos_d   = idx;
            state_d = ACQUIRE;
          end
        end

        ACQUIRE: begin
          if (!is_onehot) begin
            state_d = SEARCH;
          end else if (is_hold) begin
            state_d = ACQUIRE;
          end else if (is_dec || is_inc) begin
            // First adjacent step fixes the rotation direction.
            dir_d        = is_dec;
            pos_d        = idx;
            step_count_d = CNT_W'(1);
            state_d      = LOCKED;
          end else begin
            // Jumped somewhere non-adjacent: restart acquisition from here.
            pos_d = idx;
          end
        end

        LOCKED: begin
          if (is_hold) begin
            miss_cnt_d = '0;
          end else if (fwd_step) begin
            miss_cnt_d = '0;
            pos_d      = idx;
            if (step_count != '1) begin
              step_count_d = step_count + CNT_W'(1);
            end
          end else begin
            // Zero, multi-bit, reverse step or jump: pos is held.
            err_d = 1'b1;
            if (miss_cnt_inc == MISS_W'(MISS_LIMIT)) begin
              state_d      = SEARCH;
              step_count_d = '0;
              miss_cnt_d   = '0;
            end else begin
              miss_cnt_d = miss_cnt_inc;
            end
          end
        end

        default: begin
          state_d = SEARCH;
        end
      endcase
    end
  end

  assign locked_d = (state_d == LOCKED);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_q    <= SEARCH;
      miss_cnt_q <= '0;
      pos        <= '0;
      dir        <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      step_count <= '0;
    end else begin
      state_q    <= state_d;
      miss_cnt_q <= miss_cnt_d;
      pos        <= pos_d;
      dir        <= dir_d;
      locked     <= locked_d;
      err        <= err_d;
      step_count <= step_count_d;
    end
  end

endmodule : led_ring_decoder

// File: tb/tb_led_ring_decoder.sv
// -----------------------------------------------------------------------------
// tb_led_ring_decoder
//   Self-checking bench: directed sequences followed by randomized samples,
//   all compared against a behavioural model of the ring decoder.
// -----------------------------------------------------------------------------
module tb_led_ring_decoder;

  localparam int LED_W      = 16;
  localparam int POS_W      = 4;
  localparam int MISS_LIMIT = 3;
  localparam int CNT_W      = 16;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk_out = 1'b0;
  logic             rst;
  logic             sample_en;
  logic [LED_W-1:0] pattern_in;
  logic [POS_W-1:0] pos;
  logic             dir;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] step_count;

  led_ring_decoder #(
    .LED_W      (LED_W),
    .MISS_LIMIT (MISS_LIMIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_out    (clk_out),
    .rst        (rst),
    .sample_en  (sample_en),
    .pattern_in (pattern_in),
    .pos        (pos),
    .dir        (dir),
    .locked     (locked),
    .err        (err),
    .step_count (step_count)
  );

  always #5 clk_out = ~clk_out;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 = searching, 1 = acquiring, 2 = locked.
  int m_mode, m_pos, m_dir, m_steps, m_miss, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_dir = 0; m_steps = 0; m_miss = 0; m_err = 0;
  endtask

  task automatic model_apply(input logic en, input logic [LED_W-1:0] pat);
    int ones, lit, up, down;
    m_err = 0;
    if (!en) return;
    ones = $countones(pat);
    lit  = 0;
    for (int i = 0; i < LED_W; i++) if (pat[i]) lit = i;
    up   = (m_pos + 1) % LED_W;
    down = (m_pos + LED_W - 1) % LED_W;
    case (m_mode)
      0: if (ones == 1) begin m_pos = lit; m_mode = 1; end
      1: begin
        if (ones != 1)          m_mode = 0;
        else if (lit == m_pos)  m_mode = 1;
        else if (lit == down || lit == up) begin
          m_dir = (lit == down) ? 1 : 0;
          m_pos = lit; m_steps = 1; m_mode = 2;
        end else                m_pos = lit;
      end
      default: begin
        if (ones == 1 && lit == m_pos) m_miss = 0;
        else if (ones == 1 && lit == (m_dir ? down : up)) begin
          m_miss = 0; m_pos = lit;
          if (m_steps < CNT_MAX) m_steps++;
        end else begin
          m_err = 1;
          m_miss++;
          if (m_miss >= MISS_LIMIT) begin m_mode = 0; m_steps = 0; m_miss = 0; end
        end
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pos"},        32'(pos),        32'(m_pos));
    check({tag, ".dir"},        32'(dir),        32'(m_dir));
    check({tag, ".locked"},     32'(locked),     32'(m_mode == 2));
    check({tag, ".err"},        32'(err),        32'(m_err));
    check({tag, ".step_count"}, 32'(step_count), 32'(m_steps));
  endtask

  task automatic apply(input string tag, input logic en, input logic [LED_W-1:0] pat);
    @(negedge clk_out);
    sample_en  = en;
    pattern_in = pat;
    @(posedge clk_out);
    #1;
    model_apply(en, pat);
    compare_all(tag);
  endtask

  function automatic logic [LED_W-1:0] bit_at(input int i);
    logic [LED_W-1:0] p;
    p = '0;
    p[i % LED_W] = 1'b1;
    return p;
  endfunction

  initial begin
    logic [LED_W-1:0] p;
    int k;
    logic en;

    rst = 1'b1; sample_en = 1'b0; pattern_in = '0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk_out);
    rst = 1'b0;

    // 1. idle after reset
    for (int i = 0; i < 10; i++) apply($sformatf("idle%0d", i), 1'b0, $urandom);

    // 2. right-rotate lock
    apply("r_acq",   1'b1, 16'h0001);
    apply("r_lock",  1'b1, 16'h8000);
    check("r_lock_dir_const", 32'(dir), 32'd1);
    apply("r_step",  1'b1, 16'h4000);
    check("r_step_pos_const", 32'(pos), 32'd14);
    check("r_step_cnt_const", 32'(step_count), 32'd2);
    for (int i = 0; i < 3; i++) apply($sformatf("r_drop%0d", i), 1'b1, 16'h0000);
    check("r_drop_locked_const", 32'(locked), 32'd0);

    // 3. left-rotate with wrap
    apply("l_acq",   1'b1, 16'h4000);
    apply("l_lock",  1'b1, 16'h8000);
    apply("l_wrap",  1'b1, 16'h0001);
    check("l_wrap_pos_const", 32'(pos), 32'd0);
    apply("l_step",  1'b1, 16'h0002);
    check("l_step_cnt_const", 32'(step_count), 32'd3);

    // 5. loss of lock on repeated multi-bit samples, then re-acquire
    for (int i = 0; i < 3; i++) begin
      apply($sformatf("loss%0d", i), 1'b1, 16'h0003);
      check($sformatf("loss%0d_err_const", i), 32'(err), 32'd1);
    end
    check("loss_cnt_const", 32'(step_count), 32'd0);
    apply("reacq", 1'b1, 16'h0010);
    check("reacq_pos_const", 32'(pos), 32'd4);

    // 4. fault tolerance while locked at pos 5, dir 0
    apply("ft_lock", 1'b1, 16'h0020);
    apply("ft_zero", 1'b1, 16'h0000);
    apply("ft_multi", 1'b1, 16'h0060);
    apply("ft_good", 1'b1, 16'h0040);
    check("ft_pos_const", 32'(pos), 32'd6);
    check("ft_locked_const", 32'(locked), 32'd1);
    check("ft_cnt_const", 32'(step_count), 32'd2);

    // 6. async reset mid-lock at step_count 7
    for (int i = 7; i <= 11; i++) apply($sformatf("pre_rst%0d", i), 1'b1, bit_at(i));
    check("pre_rst_cnt_const", 32'(step_count), 32'd7);
    @(posedge clk_out);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk_out);
    rst = 1'b0;

    // Randomized samples steered around the model's position
    for (int n = 0; n < 3000; n++) begin
      k  = $urandom_range(0, 11);
      en = ($urandom_range(0, 7) != 0);
      case (k)
        0: p = '0;
        1: begin
          p = LED_W'($urandom);
          if ($countones(p) < 2) p = p | bit_at($urandom_range(0, 7)) | bit_at($urandom_range(8, 15));
        end
        2: p = bit_at(m_pos);
        3, 4, 5, 6, 7: begin
          if (m_mode == 2) p = m_dir ? bit_at(m_pos + LED_W - 1) : bit_at(m_pos + 1);
          else             p = $urandom_range(0, 1) ? bit_at(m_pos + LED_W - 1) : bit_at(m_pos + 1);
        end
        8: p = m_dir ? bit_at(m_pos + 1) : bit_at(m_pos + LED_W - 1);
        default: p = bit_at($urandom_range(0, LED_W - 1));
      endcase
      apply($sformatf("rnd%0d", n), en, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_led_ring_decoder
